roalogic_dbg_dmi: RTL and testbench

ROALOGIC_DBG_DMI -- requirements
Module: roalogic_dbg_dmi

---
 rtl/roalogic_dbg_dmi.sv | 77 +++++++
 tb/tb_roalogic_dbg_dmi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roalogic_dbg_dmi.sv
// roalogic_dbg_dmi: JTAG data register bridging scan operations onto a single-outstanding debug bus
module roalogic_dbg_dmi #(
  parameter int ABITS = 16
) (
  input  logic             jtag_tck,
  input  logic             tap_reset,
  input  logic             dbg_sel,
  input  logic             tap_CaptureDR,
  input  logic             tap_ShiftDR,
  input  logic             tap_UpdateDR,
  input  logic             dbg_tdi,
  output logic             dbg_tdo,
  output logic             bus_req,
  output logic             bus_we,
  output logic [ABITS-1:0] bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ack,
  input  logic             bus_err
);
  localparam int N = ABITS + 34;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state, state_nxt;
  logic [N-1:0]     sr;
  logic [31:0]      rdata_q;
  logic [ABITS-1:0] last_addr;
  logic             busy_err, fail_err;
  logic [1:0]       op, status;
  logic             upd, access, clr, issue, ack;
  assign op      = sr[1:0];
  assign dbg_tdo = sr[0];
  assign upd     = dbg_sel & tap_UpdateDR;
  assign access  = upd & ((op == 2'b01) | (op == 2'b10));
  assign clr     = upd & (op == 2'b11);
  assign status  = ((state == BUSY) | busy_err) ? 2'b11 : fail_err ? 2'b10 : 2'b00;
  // next state: launch only from a clean IDLE, retire on any ack while BUSY
  always_comb begin
    issue     = (state == IDLE) & access & ~busy_err & ~fail_err;
    ack       = (state == BUSY) & bus_ack;
    state_nxt = issue ? BUSY : ack ? IDLE : state;
  end
  // state register
  always_ff @(posedge jtag_tck) begin
    if (tap_reset) state <= IDLE;
    else state <= state_nxt;
  end
  // scan register: capture a status snapshot or shift LSB first
  always_ff @(posedge jtag_tck) begin
    if (tap_reset) sr <= '0;
    else if (dbg_sel & tap_CaptureDR) sr <= {last_addr, rdata_q, status};
    else if (dbg_sel & tap_ShiftDR) sr <= {dbg_tdi, sr[N-1:1]};
  end
  // bus request registers, read data capture and sticky errors
  always_ff @(posedge jtag_tck) begin
    if (tap_reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      last_addr <= '0;
      rdata_q   <= '0;
      busy_err  <= 1'b0;
      fail_err  <= 1'b0;
    end else begin
      if (issue) begin
        bus_req   <= 1'b1;
        bus_we    <= (op == 2'b10);
        bus_addr  <= sr[N-1:34];
        last_addr <= sr[N-1:34];
        bus_wdata <= sr[33:2];
      end else if (ack) bus_req <= 1'b0;
      if (ack & ~bus_we & ~bus_err) rdata_q <= bus_rdata;
      busy_err <= ~clr & (busy_err | ((state == BUSY) & access));
      fail_err <= (fail_err & ~clr) | (ack & bus_err);
    end
  end
endmodule

// File: tb/tb_roalogic_dbg_dmi.sv
// tb_roalogic_dbg_dmi: directed scenario checks of the debug DMI bridge
module tb_roalogic_dbg_dmi;
  localparam int ABITS = 16;
  localparam int N = ABITS + 34;
  logic jtag_tck = 1'b0, tap_reset = 1'b1, dbg_sel = 1'b1;
  logic tap_CaptureDR = 1'b0, tap_ShiftDR = 1'b0, tap_UpdateDR = 1'b0, dbg_tdi = 1'b0;
  logic dbg_tdo, bus_req, bus_we, bus_ack = 1'b0, bus_err = 1'b0;
  logic [ABITS-1:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata = '0;
  int n_cmp = 0, n_err = 0;
  logic [N-1:0] o;

  roalogic_dbg_dmi #(.ABITS(ABITS)) dut (
    .jtag_tck(jtag_tck), .tap_reset(tap_reset), .dbg_sel(dbg_sel),
    .tap_CaptureDR(tap_CaptureDR), .tap_ShiftDR(tap_ShiftDR), .tap_UpdateDR(tap_UpdateDR),
    .dbg_tdi(dbg_tdi), .dbg_tdo(dbg_tdo), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err));

  always #5 jtag_tck = ~jtag_tck;

  task automatic tick;
    @(posedge jtag_tck);
    #1;
  endtask

  task automatic scan(input logic [N-1:0] v, input logic cap, output logic [N-1:0] q);
    if (cap) begin
      tap_CaptureDR = 1'b1;
      tick();
      tap_CaptureDR = 1'b0;
    end
    tap_ShiftDR = 1'b1;
    for (int i = 0; i < N; i++) begin
      q[i] = dbg_tdo;
      dbg_tdi = v[i];
      tick();
    end
    tap_ShiftDR = 1'b0;
  endtask

  task automatic update;
    tap_UpdateDR = 1'b1;
    tick();
    tap_UpdateDR = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d, input logic e);
    bus_rdata = d;
    bus_err = e;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_err = 1'b0;
  endtask

  task automatic test_reset;
    tap_reset = 1'b1;
    tick();
    tick();
    tap_reset = 1'b0;
    n_cmp++;
    if ({dbg_tdo, bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got tdo=%b req=%b we=%b addr=%h wdata=%h want all zero",
               dbg_tdo, bus_req, bus_we, bus_addr, bus_wdata);
    end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== '0) begin n_err++; $display("FAIL reset_capture: got %h want %h", o, {N{1'b0}}); end
  endtask

  task automatic test_read;
    scan({16'h0040, 32'h0, 2'b01}, 1'b0, o);
    update();
    n_cmp++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      n_err++;
      $display("FAIL read_issue: got req=%b we=%b addr=%h want 1 0 0040", bus_req, bus_we, bus_addr);
    end
    tick();
    ack(32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL read_req_drop: got %b want 0", bus_req); end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0040, 32'hDEADBEEF, 2'b00}) begin
      n_err++;
      $display("FAIL read_capture: got %h want %h", o, {16'h0040, 32'hDEADBEEF, 2'b00});
    end
  endtask

  task automatic test_write;
    scan({16'h0010, 32'h12345678, 2'b10}, 1'b0, o);
    update();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 16'h0010, 32'h12345678}) begin
        n_err++;
        $display("FAIL write_hold[%0d]: got req=%b we=%b addr=%h wdata=%h want 1 1 0010 12345678",
                 i, bus_req, bus_we, bus_addr, bus_wdata);
      end
      tick();
    end
    ack(32'h0BADF00D, 1'b0);
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL write_req_drop: got %b want 0", bus_req); end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0010, 32'hDEADBEEF, 2'b00}) begin
      n_err++;
      $display("FAIL write_capture: got %h want %h", o, {16'h0010, 32'hDEADBEEF, 2'b00});
    end
  endtask

  task automatic test_busy;
    scan({16'h0020, 32'h0, 2'b01}, 1'b0, o);
    update();
    scan({16'h0030, 32'h0, 2'b01}, 1'b0, o);
    update();
    n_cmp++;
    if ({bus_req, bus_addr} !== {1'b1, 16'h0020}) begin
      n_err++;
      $display("FAIL busy_no_reissue: got req=%b addr=%h want 1 0020", bus_req, bus_addr);
    end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0020, 32'hDEADBEEF, 2'b11}) begin
      n_err++;
      $display("FAIL busy_capture: got %h want %h", o, {16'h0020, 32'hDEADBEEF, 2'b11});
    end
    ack(32'hCAFEF00D, 1'b0);
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0020, 32'hCAFEF00D, 2'b11}) begin
      n_err++;
      $display("FAIL busy_sticky: got %h want %h", o, {16'h0020, 32'hCAFEF00D, 2'b11});
    end
    scan({16'h0, 32'h0, 2'b11}, 1'b0, o);
    update();
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0020, 32'hCAFEF00D, 2'b00}) begin
      n_err++;
      $display("FAIL busy_clear: got %h want %h", o, {16'h0020, 32'hCAFEF00D, 2'b00});
    end
  endtask

  task automatic test_ack_capture;
    scan({16'h0050, 32'h0, 2'b01}, 1'b0, o);
    update();
    tap_CaptureDR = 1'b1;
    ack(32'h11112222, 1'b0);
    tap_CaptureDR = 1'b0;
    scan('0, 1'b0, o);
    n_cmp++;
    if (o !== {16'h0050, 32'hCAFEF00D, 2'b11}) begin
      n_err++;
      $display("FAIL ack_cycle_capture: got %h want %h", o, {16'h0050, 32'hCAFEF00D, 2'b11});
    end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0050, 32'h11112222, 2'b00}) begin
      n_err++;
      $display("FAIL after_ack_capture: got %h want %h", o, {16'h0050, 32'h11112222, 2'b00});
    end
  endtask

  task automatic test_ack_update;
    scan({16'h0058, 32'h0, 2'b01}, 1'b0, o);
    update();
    tap_UpdateDR = 1'b1;
    ack(32'h33334444, 1'b0);
    tap_UpdateDR = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL ack_update_req: got %b want 0", bus_req); end
    tick();
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL ack_update_req_late: got %b want 0", bus_req); end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0058, 32'h33334444, 2'b11}) begin
      n_err++;
      $display("FAIL ack_update_capture: got %h want %h", o, {16'h0058, 32'h33334444, 2'b11});
    end
    scan({16'h0, 32'h0, 2'b11}, 1'b0, o);
    update();
  endtask

  task automatic test_back_to_back;
    scan({16'h0090, 32'h0, 2'b01}, 1'b0, o);
    update();
    ack(32'h55556666, 1'b0);
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", bus_req); end
    update();
    n_cmp++;
    if ({bus_req, bus_addr} !== {1'b1, 16'h0090}) begin
      n_err++;
      $display("FAIL b2b_reissue: got req=%b addr=%h want 1 0090", bus_req, bus_addr);
    end
    ack(32'h77778888, 1'b0);
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0090, 32'h77778888, 2'b00}) begin
      n_err++;
      $display("FAIL b2b_capture: got %h want %h", o, {16'h0090, 32'h77778888, 2'b00});
    end
  endtask

  task automatic test_bus_err;
    scan({16'h0060, 32'h0, 2'b01}, 1'b0, o);
    update();
    ack(32'hBAD0BAD0, 1'b1);
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0060, 32'h77778888, 2'b10}) begin
      n_err++;
      $display("FAIL err_capture: got %h want %h", o, {16'h0060, 32'h77778888, 2'b10});
    end
    scan({16'h0068, 32'h0, 2'b01}, 1'b0, o);
    update();
    tick();
    n_cmp++;
    if (bus_req !== 1'b0) begin n_err++; $display("FAIL err_blocks_read: got %b want 0", bus_req); end
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0060, 32'h77778888, 2'b10}) begin
      n_err++;
      $display("FAIL err_unchanged: got %h want %h", o, {16'h0060, 32'h77778888, 2'b10});
    end
    scan({16'h0, 32'h0, 2'b11}, 1'b0, o);
    update();
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== {16'h0060, 32'h77778888, 2'b00}) begin
      n_err++;
      $display("FAIL err_clear: got %h want %h", o, {16'h0060, 32'h77778888, 2'b00});
    end
  endtask

  task automatic test_reset_mid;
    scan({16'h0070, 32'h0, 2'b01}, 1'b0, o);
    update();
    tap_reset = 1'b1;
    tick();
    tap_reset = 1'b0;
    n_cmp++;
    if ({bus_req, bus_addr} !== {1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_mid_req: got req=%b addr=%h want 0 0000", bus_req, bus_addr);
    end
    ack(32'hFFFFFFFF, 1'b0);
    scan('0, 1'b1, o);
    n_cmp++;
    if (o !== '0) begin n_err++; $display("FAIL reset_mid_capture: got %h want %h", o, {N{1'b0}}); end
  endtask

  task automatic test_sel_low;
    logic [N-1:0] v;
    v = {16'h0080, 32'hA5A5A5A5, 2'b01};
    scan(v, 1'b0, o);
    dbg_sel = 1'b0;
    scan(~v, 1'b1, o);
    update();
    tick();
    n_cmp++;
    if ({bus_req, dbg_tdo} !== 2'b01) begin
      n_err++;
      $display("FAIL sel_low_quiet: got req=%b tdo=%b want 0 1", bus_req, dbg_tdo);
    end
    dbg_sel = 1'b1;
    scan('0, 1'b0, o);
    n_cmp++;
    if (o !== v) begin n_err++; $display("FAIL sel_low_sr: got %h want %h", o, v); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_busy();
    test_ack_capture();
    test_ack_update();
    test_back_to_back();
    test_bus_err();
    test_reset_mid();
    test_sel_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
